mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-002 The block SHALL have the port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 The block SHALL have the ports i_read and i_write, input, 1 bit each: I-cache read and write requests, held high until i_ready.
REQ-004 The block SHALL have the ports i_addr (input, 28 bits [31:4]), i_wdata (input, 128 bits), i_rdata (output, 128 bits) and i_ready (output, 1 bit): I-cache line address, write data, read data and one-cycle done pulse.
REQ-005 The block SHALL have the ports d_read, d_write, d_addr[31:4], d_wdata[127:0], d_rdata[127:0] and d_ready: D-cache port with the same directions and meaning as the I-cache port.
REQ-006 The block SHALL have the ports mem_read and mem_write, output, 1 bit each: shared slow-memory request.
REQ-007 The block SHALL have the ports mem_addr (output, 28 bits [31:4]) and mem_wdata (output, 128 bits): shared slow-memory line address and write data.
REQ-008 The block SHALL have the ports mem_rdata (input, 128 bits) and mem_ready (input, 1 bit): slow-memory read data and completion strobe.
REQ-009 The block SHALL have the port arb_busy, output, 1 bit: high while a transaction is in BUSY or RESP.

Function
REQ-010 The block SHALL implement the FSM states IDLE, BUSY and RESP.
REQ-011 IDLE: the block SHALL sample requests, and with any request pending it SHALL latch the winner's id, read, write, addr and wdata into registers and go to BUSY on the next edge.
REQ-012 A requester SHALL be requesting when read|write is high; read and write both high SHALL be treated as a write (mem_read=0, mem_write=1).
REQ-013 BUSY: mem_read, mem_write, mem_addr and mem_wdata SHALL be driven only from the latched registers and SHALL stay stable until mem_ready.
REQ-014 BUSY with mem_ready=1: the block SHALL capture mem_rdata into the winner's rdata register, clear mem_read and mem_write, and go to RESP.
REQ-015 RESP: the block SHALL drive the winner's ready high for exactly one cycle, then return to IDLE; the loser's ready SHALL stay 0.
REQ-016 i_rdata and d_rdata SHALL hold their last captured value until the next read completes for that port; write completions SHALL leave rdata unchanged.
REQ-017 Minimum latency SHALL be request-to-mem_read 1 cycle, and mem_ready-to-requester ready 1 cycle.
REQ-018 Back-to-back transactions SHALL take 1 IDLE cycle between RESP and the next BUSY.
REQ-019 Requests that arrive during BUSY or RESP SHALL wait, and changes to a request's inputs after the grant SHALL not affect the transaction in flight.
REQ-020 Arbitration SHALL apply only in IDLE and SHALL use fixed priority D over I unless REQ-025 applies.
REQ-021 mem_ready seen in IDLE or RESP SHALL be ignored.

Reset
REQ-022 On rst_n=0 the block SHALL at once set the state to IDLE and set mem_read, mem_write, i_ready, d_ready and arb_busy to 0.
REQ-023 On rst_n=0 the block SHALL also set mem_addr, mem_wdata, i_rdata and d_rdata to 0, and reset the round-robin pointer to I.
REQ-024 A transaction in flight at reset SHALL be dropped with no ready pulse; after rst_n rises, the first arbitration SHALL happen on the first edge.

Configuration
REQ-025 With the macro MEM_ARB_RR_EN defined, arbitration SHALL be round-robin: on a tie, grant the port not granted last.
REQ-026 Under MEM_ARB_RR_EN, the pointer SHALL update on each grant and reset to "last=I", so D wins the first tie.
REQ-027 Without MEM_ARB_RR_EN, the block SHALL use fixed D-over-I priority and SHALL not include the pointer register.

Verification
REQ-028 Case 1: i_read=1 with i_addr=28'h0000010, and memory returns 128'hA5 after 4 cycles -> mem_read=1 and mem_addr=28'h0000010 one cycle after the request; i_ready pulses once with i_rdata=128'hA5; d_ready stays 0.
REQ-029 Case 2: d_write=1 with d_addr=28'h0000020 and d_wdata=128'h1234 -> mem_write=1 with those values until mem_ready; d_ready pulses once; d_rdata is unchanged.
REQ-030 Case 3: i_read and d_read asserted in the same cycle and both held, without the macro -> D is served first, then after one IDLE cycle I is served; exactly two mem_read transactions.
REQ-031 Case 4: with MEM_ARB_RR_EN, both ports request continuously for 4 transactions -> grant order D, I, D, I.
REQ-032 Case 5: rst_n pulled low during BUSY -> mem_read, mem_write and arb_busy are 0 with no clock edge; no ready pulse; a request held through reset is served normally afterwards.
REQ-033 Case 6: mem_ready pulsed while in IDLE -> no state change and no ready pulse.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Handshake bundle between the I/D cache ports, the shared slow-memory port and the arbiter.
// slave is the arbiter's view; master is the environment (caches plus memory).
interface mem_arbiter_if;
  logic         i_read;
  logic         i_write;
  logic [31:4]  i_addr;
  logic [127:0] i_wdata;
  logic [127:0] i_rdata;
  logic         i_ready;

  logic         d_read;
  logic         d_write;
  logic [31:4]  d_addr;
  logic [127:0] d_wdata;
  logic [127:0] d_rdata;
  logic         d_ready;

  logic         mem_read;
  logic         mem_write;
  logic [31:4]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  logic         arb_busy;

  modport slave (
    input  i_read, i_write, i_addr, i_wdata,
    output i_rdata, i_ready,
    input  d_read, d_write, d_addr, d_wdata,
    output d_rdata, d_ready,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready,
    output arb_busy
  );

  modport master (
    output i_read, i_write, i_addr, i_wdata,
    input  i_rdata, i_ready,
    output d_read, d_write, d_addr, d_wdata,
    input  d_rdata, d_ready,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_ready,
    input  arb_busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one slow-memory line port between the I-cache and D-cache.
// Define MEM_ARB_RR_EN for round-robin tie-break; default is fixed D-over-I priority.
//
// state | meaning
// IDLE  | sample requests; a pending request is latched and granted on the next edge
// BUSY  | memory request driven from latched registers until mem_ready
// RESP  | one-cycle ready pulse to the winner, then back to IDLE
module mem_arbiter (
  input  logic         clk,
  input  logic         rst_n,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t       state;
  state_t       state_nxt;

  logic         i_req;
  logic         d_req;
  logic         any_req;
  logic         grant_d;
  logic         sel_write;
  logic         grant_en;
  logic         done_en;

  logic         win_d;
  logic         mem_read_q;
  logic         mem_write_q;
  logic [31:4]  addr_q;
  logic [127:0] wdata_q;
  logic [127:0] i_rdata_q;
  logic [127:0] d_rdata_q;

  assign i_req    = bus.i_read | bus.i_write;
  assign d_req    = bus.d_read | bus.d_write;
  assign any_req  = i_req | d_req;
  assign grant_en = (state == IDLE) & any_req;
  assign done_en  = (state == BUSY) & bus.mem_ready;

`ifdef MEM_ARB_RR_EN
  // last_d = 1 when D took the most recent grant; reset value favours D on the first tie
  logic last_d;

  always_comb begin
    grant_d = 1'b0;
    if (d_req && (!i_req || !last_d)) begin
      grant_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_d <= 1'b0;
    end else if (grant_en) begin
      last_d <= grant_d;
    end
  end
`else
  always_comb begin
    grant_d = d_req;
  end
`endif

  // read and write together count as a write
  assign sel_write = grant_d ? bus.d_write : bus.i_write;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = BUSY;
      BUSY:    if (bus.mem_ready) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_d       <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else if (grant_en) begin
      win_d       <= grant_d;
      mem_read_q  <= ~sel_write;
      mem_write_q <= sel_write;
      addr_q      <= grant_d ? bus.d_addr  : bus.i_addr;
      wdata_q     <= grant_d ? bus.d_wdata : bus.i_wdata;
    end else if (done_en) begin
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      if (mem_read_q && win_d) begin
        d_rdata_q <= bus.mem_rdata;
      end
      if (mem_read_q && !win_d) begin
        i_rdata_q <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.i_ready   = (state == RESP) & ~win_d;
  assign bus.d_ready   = (state == RESP) & win_d;
  assign bus.arb_busy  = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: requesters push expectations, monitors on the
// memory side and the ready side pop and compare; grant order comes from a priority model.
`timescale 1ns/1ps
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_arbiter_if bus();

  mem_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic         wr;
    logic [27:0]  addr;
    logic [127:0] wdata;
  } mem_exp_t;

  typedef struct packed {
    logic         wr;
    logic [127:0] rdata;
  } rsp_exp_t;

  mem_exp_t     mem_q_i[$];
  mem_exp_t     mem_q_d[$];
  rsp_exp_t     rsp_q_i[$];
  rsp_exp_t     rsp_q_d[$];
  logic [27:0]  addr_log[$];
  logic [127:0] gmem [logic [27:0]];
  logic [127:0] last_rd_i = '0;
  logic [127:0] last_rd_d = '0;

  int vectors     = 0;
  int miscompares = 0;
  int ntx         = 0;
  int fdelay      = -1;
  bit poke        = 1'b0;
  bit rand_poke   = 1'b0;
  bit model_last_d = 1'b0;
  logic smp_i = 1'b0;
  logic smp_d = 1'b0;

  function automatic logic [127:0] mem_val(input logic [27:0] a);
    if (gmem.exists(a)) return gmem[a];
    return {a, 4'h0, ~a, 4'hF, a, 4'h5, ~a, 4'hA};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: got event expected none", name);
  endtask

  task automatic model_reset;
    model_last_d = 1'b0;
    last_rd_i    = '0;
    last_rd_d    = '0;
  endtask

  // one request held until its ready; expectations are queued at issue time
  task automatic do_txn(input bit d, input bit rd, input bit wr,
                        input logic [27:0] a, input logic [127:0] w);
    mem_exp_t me;
    rsp_exp_t re;
    bit got;
    me.wr = wr; me.addr = a; me.wdata = w;
    re.wr = wr; re.rdata = wr ? '0 : mem_val(a);
    if (d) begin
      mem_q_d.push_back(me); rsp_q_d.push_back(re);
      bus.d_addr = a; bus.d_wdata = w; bus.d_read = rd; bus.d_write = wr;
    end else begin
      mem_q_i.push_back(me); rsp_q_i.push_back(re);
      bus.i_addr = a; bus.i_wdata = w; bus.i_read = rd; bus.i_write = wr;
    end
    got = 1'b0;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk);
      got = d ? bus.d_ready : bus.i_ready;
    end
    if (!got) fail_evt(d ? "d_req_timeout" : "i_req_timeout");
    if (d) begin bus.d_read = 1'b0; bus.d_write = 1'b0; end
    else   begin bus.i_read = 1'b0; bus.i_write = 1'b0; end
  endtask

  task automatic port_rsp(input bit d);
    rsp_exp_t e;
    logic [127:0] act;
    act = d ? bus.d_rdata : bus.i_rdata;
    if (d) begin
      if (rsp_q_d.size() == 0) begin fail_evt("d_ready_spurious"); return; end
      e = rsp_q_d.pop_front();
      if (e.wr) check("d_rdata_after_write", act, last_rd_d);
      else begin check("d_rdata", act, e.rdata); last_rd_d = e.rdata; end
    end else begin
      if (rsp_q_i.size() == 0) begin fail_evt("i_ready_spurious"); return; end
      e = rsp_q_i.pop_front();
      if (e.wr) check("i_rdata_after_write", act, last_rd_i);
      else begin check("i_rdata", act, e.rdata); last_rd_i = e.rdata; end
    end
  endtask

  initial forever begin
    @(posedge clk);
    smp_i = bus.i_read | bus.i_write;
    smp_d = bus.d_read | bus.d_write;
  end

  initial begin
    logic pi, pd;
    pi = 1'b0; pd = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.i_ready && pi) fail_evt("i_ready_width");
        if (bus.d_ready && pd) fail_evt("d_ready_width");
        if (bus.i_ready && bus.d_ready) fail_evt("both_ready");
        if (bus.i_ready) port_rsp(1'b0);
        if (bus.d_ready) port_rsp(1'b1);
      end
      pi = bus.i_ready;
      pd = bus.d_ready;
    end
  end

  // memory responder and memory-side monitor
  initial begin
    bit active, win, stable;
    int cnt;
    mem_exp_t cap, e;
    active = 1'b0; cnt = 0; win = 1'b0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        active = 1'b0;
        bus.mem_ready = 1'b0;
      end else begin
        if (bus.mem_ready) bus.mem_ready = 1'b0;
        if (active) begin
          stable = (bus.mem_write == cap.wr) && (bus.mem_read == !cap.wr) &&
                   (bus.mem_addr == cap.addr) && (bus.mem_wdata == cap.wdata);
          check("mem_stable", 128'(stable), 128'(1'b1));
          if (cnt == 0) begin
            bus.mem_ready = 1'b1;
            if (cap.wr) begin
              gmem[cap.addr] = cap.wdata;
              bus.mem_rdata = {4{$urandom}};
            end else begin
              bus.mem_rdata = mem_val(cap.addr);
            end
            if (win) void'(mem_q_d.pop_front());
            else     void'(mem_q_i.pop_front());
            addr_log.push_back(cap.addr);
            ntx++;
            active = 1'b0;
          end else begin
            cnt--;
          end
        end else if (bus.mem_read || bus.mem_write) begin
          check("busy_in_txn", 128'(bus.arb_busy), 128'(1'b1));
          if (smp_i && smp_d) begin
`ifdef MEM_ARB_RR_EN
            win = !model_last_d;
`else
            win = 1'b1;
`endif
          end else if (smp_d) win = 1'b1;
          else if (smp_i) win = 1'b0;
          else begin fail_evt("grant_without_request"); win = 1'b0; end
          model_last_d = win;
          if ((win && mem_q_d.size() == 0) || (!win && mem_q_i.size() == 0)) begin
            fail_evt(win ? "grant_d_unexpected" : "grant_i_unexpected");
          end else begin
            e = win ? mem_q_d[0] : mem_q_i[0];
            check(win ? "d_mem_op" : "i_mem_op",
                  128'({bus.mem_read, bus.mem_write}), 128'({!e.wr, e.wr}));
            check(win ? "d_mem_addr" : "i_mem_addr", 128'(bus.mem_addr), 128'(e.addr));
            if (e.wr) check(win ? "d_mem_wdata" : "i_mem_wdata", bus.mem_wdata, e.wdata);
          end
          cap.wr = bus.mem_write; cap.addr = bus.mem_addr; cap.wdata = bus.mem_wdata;
          cnt = (fdelay > 0) ? fdelay - 1 : int'($urandom_range(0, 4));
          active = 1'b1;
        end else if (!bus.arb_busy && (poke || (rand_poke && $urandom_range(0, 7) == 0))) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = {4{$urandom}};
          poke = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int n0, s, w;
    logic [27:0] e3, e4[4];
    bus.i_read = 0; bus.i_write = 0; bus.i_addr = '0; bus.i_wdata = '0;
    bus.d_read = 0; bus.d_write = 0; bus.d_addr = '0; bus.d_wdata = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_ctrl", 128'({bus.mem_read, bus.mem_write, bus.i_ready, bus.d_ready, bus.arb_busy}), '0);
    check("rst_mem_addr", 128'(bus.mem_addr), '0);
    check("rst_mem_wdata", bus.mem_wdata, '0);
    check("rst_i_rdata", bus.i_rdata, '0);
    check("rst_d_rdata", bus.d_rdata, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // case 1: I read, fixed 4-cycle memory, request inputs scrambled after grant
    gmem[28'h0000010] = 128'hA5;
    fdelay = 4;
    fork
      do_txn(1'b0, 1'b1, 1'b0, 28'h0000010, '0);
      begin
        @(negedge clk);
        check("c1_mem_read", 128'(bus.mem_read), 128'(1'b1));
        check("c1_mem_addr", 128'(bus.mem_addr), 128'(28'h0000010));
        bus.i_addr  = 28'hFFFFFFF;
        bus.i_wdata = {4{32'hDEADBEEF}};
      end
    join
    check("c1_i_rdata_hold", bus.i_rdata, 128'hA5);

    // case 2: D write leaves d_rdata untouched
    fdelay = 3;
    do_txn(1'b1, 1'b0, 1'b1, 28'h0000020, 128'h1234);
    check("c2_d_rdata_hold", bus.d_rdata, '0);

    // case 3: simultaneous reads
    fdelay = -1;
    n0 = ntx;
    fork
      do_txn(1'b1, 1'b1, 1'b0, 28'h0000030, '0);
      do_txn(1'b0, 1'b1, 1'b0, 28'h0000040, '0);
    join
    check("c3_tx_count", 128'(ntx - n0), 128'(2));
`ifdef MEM_ARB_RR_EN
    e3 = 28'h0000040;
`else
    e3 = 28'h0000030;
`endif
    s = addr_log.size();
    check("c3_first_grant", 128'(addr_log[s-2]), 128'(e3));

    // case 4: both ports back-to-back, starting from a fresh pointer
    #2 rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    fork
      begin do_txn(1'b1, 1'b1, 1'b0, 28'h0000200, '0); do_txn(1'b1, 1'b1, 1'b0, 28'h0000201, '0); end
      begin do_txn(1'b0, 1'b1, 1'b0, 28'h0000100, '0); do_txn(1'b0, 1'b1, 1'b0, 28'h0000101, '0); end
    join
`ifdef MEM_ARB_RR_EN
    e4[0] = 28'h200; e4[1] = 28'h100; e4[2] = 28'h201; e4[3] = 28'h101;
`else
    e4[0] = 28'h200; e4[1] = 28'h201; e4[2] = 28'h100; e4[3] = 28'h101;
`endif
    s = addr_log.size();
    for (int k = 0; k < 4; k++) check($sformatf("c4_order%0d", k), 128'(addr_log[s-4+k]), 128'(e4[k]));

    // case 5: reset mid-transaction, request held through it
    fdelay = 6;
    fork
      do_txn(1'b0, 1'b1, 1'b0, 28'h0000050, '0);
      begin
        w = 0;
        do begin @(negedge clk); w++; end while (!bus.arb_busy && w < 20);
        if (!bus.arb_busy) fail_evt("c5_never_busy");
        #2 rst_n = 1'b0;
        #1;
        check("c5_async_ctrl", 128'({bus.mem_read, bus.mem_write, bus.arb_busy, bus.i_ready}), '0);
        check("c5_i_rdata_rst", bus.i_rdata, '0);
        model_reset();
        @(negedge clk);
        #2 rst_n = 1'b1;
      end
    join
    fdelay = -1;

    // case 6: stray mem_ready while idle
    @(negedge clk);
    poke = 1'b1;
    repeat (3) @(negedge clk);
    check("c6_idle", 128'({bus.arb_busy, bus.mem_read, bus.mem_write, bus.i_ready, bus.d_ready}), '0);

    // random traffic on disjoint address spaces
    rand_poke = 1'b1;
    fork
      for (int n = 0; n < 30; n++) begin
        automatic int op = int'($urandom_range(0, 7));
        repeat ($urandom_range(0, 3)) @(negedge clk);
        do_txn(1'b0, op < 4 || op == 7, op >= 4, {1'b0, 23'h0, 4'($urandom_range(0, 15))}, {4{$urandom}});
      end
      for (int n = 0; n < 30; n++) begin
        automatic int op = int'($urandom_range(0, 7));
        repeat ($urandom_range(0, 3)) @(negedge clk);
        do_txn(1'b1, op < 4 || op == 7, op >= 4, {1'b1, 23'h0, 4'($urandom_range(0, 15))}, {4{$urandom}});
      end
    join
    rand_poke = 1'b0;

    repeat (6) @(negedge clk);
    check("end_busy", 128'(bus.arb_busy), '0);
    check("end_rsp_q", 128'(rsp_q_i.size() + rsp_q_d.size()), '0);
    check("end_mem_q", 128'(mem_q_i.size() + mem_q_d.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
